// File: rtl/triangle_pixel_iterator.sv
// Bounding-box pixel iterator: takes one setup triangle, clamps its screen box
// to the framebuffer and streams every covered coordinate in row-major order.

package fixed_pkg;
    localparam int FIXED_WIDTH = 32;
    localparam int FRAC_BITS   = 16;
    typedef logic signed [FIXED_WIDTH-1:0] fixed_t;
endpackage

package raster_pkg;
    import fixed_pkg::*;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
    } vec2_t;

    typedef struct packed {
        vec2_t       position;
        logic [23:0] color;
    } vertex_t;

    typedef struct packed {
        vertex_t a;
        vertex_t b;
        vertex_t c;
        fixed_t  area_inv;
    } attributed_triangle_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pixel_coordinate_t;

    typedef struct packed {
        logic last;
    } pixel_coordinate_metadata_t;
endpackage

module triangle_pixel_iterator
    import fixed_pkg::*;
    import raster_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     triangle_s_valid,
    output logic                                     triangle_s_ready,
    input  logic [$bits(attributed_triangle_t)-1:0]  triangle_s_data,
    output logic [$bits(attributed_triangle_t)-1:0]  triangle_out,
    output logic                                     coord_m_valid,
    input  logic                                     coord_m_ready,
    output logic [$bits(pixel_coordinate_t)-1:0]     coord_m_data,
    output logic [$bits(pixel_coordinate_metadata_t)-1:0] coord_m_metadata,
    output logic                                     busy
);

    localparam int PIX_W = FIXED_WIDTH - FRAC_BITS;
    typedef logic signed [PIX_W-1:0] pix_t;
    typedef logic [9:0] cnt_t;

    localparam pix_t X_LAST = pix_t'(SCREEN_WIDTH - 1);
    localparam pix_t Y_LAST = pix_t'(SCREEN_HEIGHT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    logic [1:0]           state;
    attributed_triangle_t tri_q;
    cnt_t                 x, y;
    cnt_t                 xmin_q, xmax_q, ymax_q;

    pix_t ax, ay, bx, by, cx, cy;
    pix_t px_min, px_max, py_min, py_max;
    logic box_empty;
    cnt_t x_lo, x_hi, y_lo, y_hi;
    logic last;
    logic accept;

    // Arithmetic shift of a signed fixed value floors toward minus infinity.
    function automatic pix_t to_pixel(input fixed_t v);
        return pix_t'(v >>> FRAC_BITS);
    endfunction

    function automatic pix_t min3(input pix_t p, input pix_t q, input pix_t r);
        pix_t m;
        m = (p < q) ? p : q;
        return (r < m) ? r : m;
    endfunction

    function automatic pix_t max3(input pix_t p, input pix_t q, input pix_t r);
        pix_t m;
        m = (p > q) ? p : q;
        return (r > m) ? r : m;
    endfunction

    always_comb begin
        ax = to_pixel(tri_q.a.position.x);
        ay = to_pixel(tri_q.a.position.y);
        bx = to_pixel(tri_q.b.position.x);
        by = to_pixel(tri_q.b.position.y);
        cx = to_pixel(tri_q.c.position.x);
        cy = to_pixel(tri_q.c.position.y);

        px_min = min3(ax, bx, cx);
        px_max = max3(ax, bx, cx);
        py_min = min3(ay, by, cy);
        py_max = max3(ay, by, cy);

        // Reject on the unclamped signed box so far-off triangles never wrap in.
        box_empty = (px_max < 0) || (py_max < 0) || (px_min > X_LAST) || (py_min > Y_LAST);

        x_lo = (px_min < 0)      ? '0           : cnt_t'(px_min);
        y_lo = (py_min < 0)      ? '0           : cnt_t'(py_min);
        x_hi = (px_max > X_LAST) ? cnt_t'(X_LAST) : cnt_t'(px_max);
        y_hi = (py_max > Y_LAST) ? cnt_t'(Y_LAST) : cnt_t'(py_max);
    end

    assign triangle_s_ready = (state == IDLE) && !reset;
    assign accept           = (state == IDLE) && triangle_s_valid;
    assign busy             = (state != IDLE);
    assign coord_m_valid    = (state == EMIT);
    assign last             = (state == EMIT) && (x == xmax_q) && (y == ymax_q);
    assign coord_m_data     = {x, y};
    assign coord_m_metadata = last;
    assign triangle_out     = tri_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tri_q  <= '0;
            x      <= '0;
            y      <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tri_q <= triangle_s_data;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (box_empty) begin
                        state <= IDLE;
                    end else begin
                        x      <= x_lo;
                        y      <= y_lo;
                        xmin_q <= x_lo;
                        xmax_q <= x_hi;
                        ymax_q <= y_hi;
                        state  <= EMIT;
                    end
                end
                EMIT: begin
                    if (coord_m_ready) begin
                        if (last) begin
                            state <= IDLE;
                        end else if (x == xmax_q) begin
                            x <= xmin_q;
                            y <= y + 10'd1;
                        end else begin
                            x <= x + 10'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_pixel_iterator.sv
// Directed bench for triangle_pixel_iterator; expected coordinates come from a
// real-valued bounding-box model pushed into a scoreboard queue.

module tb_triangle_pixel_iterator;
    import fixed_pkg::*;
    import raster_pkg::*;

    localparam int W = 320;
    localparam int H = 240;

    logic clk = 1'b0;
    logic reset;
    logic triangle_s_valid;
    logic triangle_s_ready;
    logic [$bits(attributed_triangle_t)-1:0] triangle_s_data;
    logic [$bits(attributed_triangle_t)-1:0] triangle_out;
    logic coord_m_valid;
    logic coord_m_ready;
    logic [$bits(pixel_coordinate_t)-1:0] coord_m_data;
    logic [$bits(pixel_coordinate_metadata_t)-1:0] coord_m_metadata;
    logic busy;

    int checks = 0;
    int errors = 0;
    logic [20:0] sb[$];

    triangle_pixel_iterator #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .clk(clk),
        .reset(reset),
        .triangle_s_valid(triangle_s_valid),
        .triangle_s_ready(triangle_s_ready),
        .triangle_s_data(triangle_s_data),
        .triangle_out(triangle_out),
        .coord_m_valid(coord_m_valid),
        .coord_m_ready(coord_m_ready),
        .coord_m_data(coord_m_data),
        .coord_m_metadata(coord_m_metadata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fixed_t fx(input real r);
        return fixed_t'($rtoi(r * 65536.0));
    endfunction

    function automatic attributed_triangle_t mk_tri(input real ax, input real ay, input real bx,
                                                    input real by, input real cx, input real cy,
                                                    input logic [31:0] ainv);
        attributed_triangle_t t;
        t.a.position.x = fx(ax);
        t.a.position.y = fx(ay);
        t.a.color      = 24'hA1B2C3;
        t.b.position.x = fx(bx);
        t.b.position.y = fx(by);
        t.b.color      = 24'h0F1E2D;
        t.c.position.x = fx(cx);
        t.c.position.y = fx(cy);
        t.c.color      = 24'h5A5A5A;
        t.area_inv     = ainv;
        return t;
    endfunction

    task automatic push_box(input real ax, input real ay, input real bx,
                            input real by, input real cx, input real cy);
        int x0, x1, y0, y1;
        int fxa, fxb, fxc, fya, fyb, fyc;
        fxa = $rtoi($floor(ax)); fxb = $rtoi($floor(bx)); fxc = $rtoi($floor(cx));
        fya = $rtoi($floor(ay)); fyb = $rtoi($floor(by)); fyc = $rtoi($floor(cy));
        x0 = fxa; if (fxb < x0) x0 = fxb; if (fxc < x0) x0 = fxc;
        x1 = fxa; if (fxb > x1) x1 = fxb; if (fxc > x1) x1 = fxc;
        y0 = fya; if (fyb < y0) y0 = fyb; if (fyc < y0) y0 = fyc;
        y1 = fya; if (fyb > y1) y1 = fyb; if (fyc > y1) y1 = fyc;
        if (x1 < 0 || y1 < 0 || x0 > W - 1 || y0 > H - 1) return;
        if (x0 < 0) x0 = 0;
        if (y0 < 0) y0 = 0;
        if (x1 > W - 1) x1 = W - 1;
        if (y1 > H - 1) y1 = H - 1;
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                sb.push_back({10'(xx), 10'(yy), (xx == x1 && yy == y1)});
    endtask

    // Returns at the negedge of the SETUP cycle, with valid already dropped.
    task automatic send(input attributed_triangle_t t);
        int n;
        n = 0;
        triangle_s_data  = t;
        triangle_s_valid = 1'b1;
        while (!triangle_s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", triangle_s_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        triangle_s_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle, input int stop_after, input bit first_valid);
        logic [20:0] e;
        logic [19:0] held_data;
        logic        held_last;
        bit          held;
        int          pops, limit, k;
        held = 0; pops = 0; k = 0;
        held_data = '0; held_last = 1'b0;
        limit = (stop_after == 0) ? 32'h3fff_ffff : stop_after;
        for (int n = 0; n < budget && sb.size() > 0 && pops < limit; n++) begin
            @(negedge clk);
            if (n == 0 && first_valid) check("first_valid", coord_m_valid, 1'b1);
            if (held) begin
                check("hold_data", coord_m_data, held_data);
                check("hold_last", coord_m_metadata[0], held_last);
            end
            coord_m_ready = toggle ? (k % 3 == 0) : 1'b1;
            k++;
            check("no_accept_busy", triangle_s_ready, 1'b0);
            if (coord_m_valid && coord_m_ready) begin
                e = sb.pop_front();
                check("coord", coord_m_data, e[20:1]);
                check("last", coord_m_metadata[0], e[0]);
                pops++;
                held = 0;
            end else begin
                held      = coord_m_valid;
                held_data = coord_m_data;
                held_last = coord_m_metadata[0];
            end
        end
        if (stop_after == 0) check("drain_left", sb.size(), 0);
        else                 check("drain_pops", pops, stop_after);
    endtask

    initial begin
        attributed_triangle_t t1, t3, t4, t5, t6, t7, junk;

        reset            = 1'b1;
        triangle_s_valid = 1'b0;
        triangle_s_data  = '0;
        coord_m_ready    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", triangle_s_ready, 1'b0);
        check("rst_valid", coord_m_valid, 1'b0);
        check("rst_data", coord_m_data, 20'd0);
        check("rst_last", coord_m_metadata, 1'b0);
        check("rst_tri", triangle_out, '0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", triangle_s_ready, 1'b1);
        coord_m_ready = 1'b1;

        // 3x3 box, constant ready
        t1 = mk_tri(2.0, 3.0, 4.5, 3.0, 2.0, 5.9, 32'h0001_2345);
        push_box(2.0, 3.0, 4.5, 3.0, 2.0, 5.9);
        send(t1);
        check("setup_valid", coord_m_valid, 1'b0);
        check("setup_busy", busy, 1'b1);
        check("setup_ready", triangle_s_ready, 1'b0);
        drain(64, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("t1_busy_end", busy, 1'b0);
        check("t1_ready_end", triangle_s_ready, 1'b1);
        check("t1_valid_end", coord_m_valid, 1'b0);

        // same triangle under back-pressure, with a competing triangle offered
        push_box(2.0, 3.0, 4.5, 3.0, 2.0, 5.9);
        send(t1);
        junk = mk_tri(100.0, 100.0, 101.0, 100.0, 100.0, 101.0, 32'hFFFF_0000);
        triangle_s_data  = junk;
        triangle_s_valid = 1'b1;
        drain(128, 1'b1, 0, 1'b0);
        check("t2_tri_held", triangle_out, t1);
        triangle_s_valid = 1'b0;
        coord_m_ready    = 1'b1;
        @(negedge clk);
        check("t2_busy_end", busy, 1'b0);

        // negative coordinates clamped to zero
        t3 = mk_tri(-3.5, -1.0, 1.2, 0.0, 0.0, 1.0, 32'h0000_8000);
        push_box(-3.5, -1.0, 1.2, 0.0, 0.0, 1.0);
        send(t3);
        drain(64, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("t3_busy_end", busy, 1'b0);

        // fully off-screen: dropped silently
        t4 = mk_tri(400.0, 10.0, 410.0, 20.0, 405.0, 30.0, 32'h0000_0100);
        send(t4);
        check("t4_setup_busy", busy, 1'b1);
        @(negedge clk);
        check("t4_valid", coord_m_valid, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_ready", triangle_s_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("t4_no_valid", coord_m_valid, 1'b0);
        end

        // single pixel, triangle pass-through
        t5 = mk_tri(7.25, 9.75, 7.25, 9.75, 7.25, 9.75, 32'hDEAD_BEEF);
        push_box(7.25, 9.75, 7.25, 9.75, 7.25, 9.75);
        send(t5);
        check("t5_tri_out", triangle_out, t5);
        drain(16, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("t5_busy_end", busy, 1'b0);

        // box clipped by the far screen corner
        t7 = mk_tri(318.5, 238.0, 330.0, 250.0, 319.0, 239.0, 32'h0000_0001);
        push_box(318.5, 238.0, 330.0, 250.0, 319.0, 239.0);
        send(t7);
        drain(32, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("t7_busy_end", busy, 1'b0);

        // reset in the middle of a 4x4 stream
        t6 = mk_tri(10.0, 20.0, 13.0, 20.0, 10.0, 23.5, 32'h0000_4000);
        push_box(10.0, 20.0, 13.0, 20.0, 10.0, 23.5);
        send(t6);
        drain(64, 1'b0, 3, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", coord_m_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", triangle_s_ready, 1'b0);
        check("mid_rst_last", coord_m_metadata, 1'b0);
        sb.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_release", triangle_s_ready, 1'b1);
        t6 = mk_tri(30.0, 40.0, 31.5, 41.25, 30.0, 40.0, 32'h0002_0000);
        push_box(30.0, 40.0, 31.5, 41.25, 30.0, 40.0);
        send(t6);
        drain(32, 1'b0, 0, 1'b1);
        @(negedge clk);
        check("after_rst_busy_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/triangle_pixel_iterator.md
Name: triangle_pixel_iterator

Overview:
Sits directly upstream of the per-pixel rasterizer and downstream of triangle setup. Accepts one attributed_triangle_t at a time and computes its screen-space bounding box, clamped to the framebuffer. Streams every pixel_coordinate_t inside that box in row-major order, with pixel_coordinate_metadata_t.last set on the final coordinate. Holds the triangle stable on an output port so the downstream edge-function stage can use it.

Parameters:
SCREEN_WIDTH, 320, horizontal pixel count; valid x is 0..SCREEN_WIDTH-1; must be ≤1024.
SCREEN_HEIGHT, 240, vertical pixel count; valid y is 0..SCREEN_HEIGHT-1; must be ≤1024.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
triangle_s_valid  in  1  upstream triangle valid
triangle_s_ready  out  1  block can accept a triangle
triangle_s_data  in  $bits(attributed_triangle_t)  input triangle with area_inv
triangle_out  out  $bits(attributed_triangle_t)  registered copy of the accepted triangle; stable from acceptance until return to IDLE
coord_m_valid  out  1  coordinate valid
coord_m_ready  in  1  downstream accepts coordinate
coord_m_data  out  $bits(pixel_coordinate_t)  current pixel {x,y}
coord_m_metadata  out  $bits(pixel_coordinate_metadata_t)  .last = final pixel of this triangle
busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Handshakes: valid/ready. A transfer occurs on a rising edge with valid && ready. Once coord_m_valid is asserted, coord_m_data and coord_m_metadata hold until transferred; valid never drops without a transfer.
- Reset values: triangle_s_ready=0 during reset and 1 on the first cycle after. coord_m_valid=0, coord_m_data=0, metadata.last=0, triangle_out=0, busy=0. State=IDLE.
- FSM states:
  - IDLE: triangle_s_ready=1. On a handshake, register the triangle into triangle_out, go to SETUP.
  - SETUP: one cycle, ready=0.
    - Per vertex: pixel integer = floor of position.x / position.y, i.e. arithmetic right shift by fixed_pkg's fractional-bit count. Negative values floor toward −∞.
    - xmin/xmax/ymin/ymax = signed min/max over vertices a, b, c.
    - Empty if xmax<0, ymax<0, xmin>SCREEN_WIDTH-1 or ymin>SCREEN_HEIGHT-1. Empty → IDLE, no coordinates emitted, triangle silently dropped.
    - Otherwise clamp xmin/ymin up to 0 and xmax/ymax down to SCREEN_WIDTH-1 / SCREEN_HEIGHT-1. Load x=xmin, y=ymin, go to EMIT.
  - EMIT: coord_m_valid=1, coord_m_data={x,y}, last=(x==xmax && y==ymax).
    - On transfer: if last → IDLE, valid=0. Else if x==xmax → x=xmin, y=y+1. Else x=x+1.
- Latency:
  - Triangle accepted at edge N.
  - First coordinate valid in the cycle after edge N+1 (SETUP occupies cycle N+1).
  - Full throughput of 1 coordinate/cycle under constant ready.
  - Ready returns high the cycle after the last transfer, so there is one IDLE bubble minimum between triangles.
- Boundaries:
  - Single-pixel box: exactly one coordinate, with last=1.
  - Degenerate/zero-area triangles are still iterated; area_inv is passed through untouched.
  - No triangle is accepted while busy.
  - coord_m_ready has no effect outside EMIT.
- Reset mid-operation: on any cycle, reset returns to IDLE with reset values. No partial stream resumes, and no last is emitted for the aborted triangle.
- Arithmetic: bounding box compare uses full signed fixed width before clamping. Counters are 10 bits unsigned after clamping.

Test Plan:
- Vertices (2.0,3.0), (4.5,3.0), (2.0,5.9), ready=1 → 9 coords in order (2,3),(3,3),(4,3),(2,4)…(4,5). last=1 only on (4,5). First valid 2 cycles after accept; busy drops the cycle after.
- Same triangle with coord_m_ready toggled 1,0,0,1,… → same 9 coords, no duplicates or skips; data stable while valid && !ready; triangle_s_ready stays 0 throughout.
- Vertices (−3.5,−1.0), (1.2,0.0), (0.0,1.0) → x clamped: (0,−1) excluded, y clamped to 0. Emits (0,0),(1,0),(0,1),(1,1); last on (1,1).
- All vertices x ≥ SCREEN_WIDTH (e.g. 400.0, defaults) → zero coordinates, coord_m_valid never high, ready back to 1 two cycles after accept.
- All vertices at (7.25,9.75) → single coord (7,9) with last=1. triangle_out equals the input, including area_inv, bit-exact.
- Assert reset after the 3rd coordinate of a 4×4 box → next cycle valid=0, busy=0; after release, a new triangle streams from its own xmin,ymin.
